// File: rtl/requant_sat_pipe_pkg.sv
// Shared widths, saturation limits and shift clamp for the requantiser pipeline.
package requant_pkg;
    localparam int NUM_CH    = 4;
    localparam int I_SUM_BW  = 21;
    localparam int O_SUM_BW  = 16;
    localparam int BIAS_BW   = 16;
    localparam int SHIFT_BW  = 5;
    localparam int CNT_BW    = 32;

    localparam int SUM1_BW   = I_SUM_BW + 1;
    localparam int SUM2_BW   = I_SUM_BW + 2;
    localparam int MAX_SHIFT = I_SUM_BW + 1;

    localparam logic signed [O_SUM_BW-1:0] SAT_MAX = {1'b0, {(O_SUM_BW-1){1'b1}}};
    localparam logic signed [O_SUM_BW-1:0] SAT_MIN = {1'b1, {(O_SUM_BW-1){1'b0}}};
    localparam logic signed [SUM2_BW-1:0]  SAT_MAX_W = {{(SUM2_BW-O_SUM_BW){1'b0}}, SAT_MAX};
    localparam logic signed [SUM2_BW-1:0]  SAT_MIN_W = {{(SUM2_BW-O_SUM_BW){1'b1}}, SAT_MIN};

    // Beyond I_SUM_BW+1 every sum rounds to 0 or -1, so larger shifts collapse here.
    function automatic logic [SHIFT_BW-1:0] clamp_shift(input logic [SHIFT_BW-1:0] sh);
        if (sh > SHIFT_BW'(MAX_SHIFT)) begin
            return SHIFT_BW'(MAX_SHIFT);
        end
        return sh;
    endfunction
endpackage

// File: rtl/requant_sat_pipe_if.sv
// Input/output beat bundle of the requantiser; slave is the pipeline, master the neighbours.
interface requant_sat_pipe_if;
    import requant_pkg::*;

    logic                         i_valid;
    logic                         o_ready;
    logic [NUM_CH*I_SUM_BW-1:0]   i_psum;
    logic [NUM_CH*BIAS_BW-1:0]    i_bias;
    logic [SHIFT_BW-1:0]          i_shift;
    logic                         i_relu_en;
    logic                         o_valid;
    logic                         i_ready;
    logic [NUM_CH*O_SUM_BW-1:0]   o_psum;
    logic [NUM_CH-1:0]            o_sat_flag;

    modport master (
        output i_valid, i_psum, i_bias, i_shift, i_relu_en, i_ready,
        input  o_ready, o_valid, o_psum, o_sat_flag
    );

    modport slave (
        input  i_valid, i_psum, i_bias, i_shift, i_relu_en, i_ready,
        output o_ready, o_valid, o_psum, o_sat_flag
    );
endinterface

// File: rtl/requant_sat_pipe_sat_clip.sv
// Per-channel optional ReLU followed by two's-complement saturation to O_SUM_BW.
module sat_clip
    import requant_pkg::*;
(
    input  logic signed [SUM2_BW-1:0]  i_val,
    input  logic                       i_relu_en,
    output logic signed [O_SUM_BW-1:0] o_val,
    output logic                       o_flag
);
    logic signed [SUM2_BW-1:0] w_relu;

    always_comb begin
        w_relu = (i_relu_en && i_val[SUM2_BW-1]) ? '0 : i_val;
        o_val  = w_relu[O_SUM_BW-1:0];
        o_flag = 1'b0;
        if (w_relu > SAT_MAX_W) begin
            o_val  = SAT_MAX;
            o_flag = 1'b1;
        end else if (w_relu < SAT_MIN_W) begin
            o_val  = SAT_MIN;
            o_flag = 1'b1;
        end
    end
endmodule

// File: rtl/requant_sat_pipe.sv
// Three-stage requantiser: bias add, rounding shift, ReLU + saturate, one global stall.
// Clip-event counter is built only when REQUANT_SAT_CNT_EN is defined.
module requant_sat_pipe
    import requant_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    requant_sat_pipe_if.slave   io_bus,
    input  logic                i_clr_cnt,
    output logic [CNT_BW-1:0]   o_sat_cnt
);
    logic                        w_en;
    logic signed [SUM1_BW-1:0]   w_sum [NUM_CH];
    logic signed [SUM2_BW-1:0]   w_shr [NUM_CH];
    logic signed [SUM2_BW-1:0]   w_ext;
    logic signed [SUM2_BW-1:0]   w_half;
    logic signed [O_SUM_BW-1:0]  w_clip_val [NUM_CH];
    logic [NUM_CH-1:0]           w_clip_flag;
    logic [NUM_CH*O_SUM_BW-1:0]  w_clip_bus;

    logic                        r1_valid, r2_valid, r3_valid;
    logic signed [SUM1_BW-1:0]   r1_sum [NUM_CH];
    logic [SHIFT_BW-1:0]         r1_shift;
    logic                        r1_relu;
    logic signed [SUM2_BW-1:0]   r2_val [NUM_CH];
    logic                        r2_relu;
    logic [NUM_CH*O_SUM_BW-1:0]  r3_psum;
    logic [NUM_CH-1:0]           r3_flag;

    assign w_en              = !r3_valid || io_bus.i_ready;
    assign io_bus.o_ready    = w_en;
    assign io_bus.o_valid    = r3_valid;
    assign io_bus.o_psum     = r3_psum;
    assign io_bus.o_sat_flag = r3_flag;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_sum[c] = SUM1_BW'($signed(io_bus.i_psum[c*I_SUM_BW +: I_SUM_BW]))
                     + SUM1_BW'($signed(io_bus.i_bias[c*BIAS_BW +: BIAS_BW]));
        end
    end

    // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
    always_comb begin
        w_ext  = '0;
        w_half = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_ext = SUM2_BW'(r1_sum[c]);
            if (r1_shift == '0) begin
                w_shr[c] = w_ext;
            end else begin
                w_half   = $signed(SUM2_BW'(1) << (r1_shift - SHIFT_BW'(1)));
                w_shr[c] = (w_ext + w_half) >>> r1_shift;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_clip
        sat_clip u_sat_clip (
            .i_val     (r2_val[g]),
            .i_relu_en (r2_relu),
            .o_val     (w_clip_val[g]),
            .o_flag    (w_clip_flag[g])
        );
    end

    always_comb begin
        w_clip_bus = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_clip_bus[c*O_SUM_BW +: O_SUM_BW] = w_clip_val[c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r1_valid <= 1'b0;
            r2_valid <= 1'b0;
            r3_valid <= 1'b0;
            r1_sum   <= '{default: '0};
            r1_shift <= '0;
            r1_relu  <= 1'b0;
            r2_val   <= '{default: '0};
            r2_relu  <= 1'b0;
            r3_psum  <= '0;
            r3_flag  <= '0;
        end else if (w_en) begin
            r1_valid <= io_bus.i_valid;
            r1_sum   <= w_sum;
            r1_shift <= clamp_shift(io_bus.i_shift);
            r1_relu  <= io_bus.i_relu_en;
            r2_valid <= r1_valid;
            r2_val   <= w_shr;
            r2_relu  <= r1_relu;
            r3_valid <= r2_valid;
            r3_psum  <= w_clip_bus;
            r3_flag  <= w_clip_flag;
        end
    end

`ifdef REQUANT_SAT_CNT_EN
    logic [CNT_BW-1:0] r_sat_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr_cnt) begin
            r_sat_cnt <= '0;
        end else if (r3_valid && io_bus.i_ready && (|r3_flag) && (r_sat_cnt != '1)) begin
            r_sat_cnt <= r_sat_cnt + CNT_BW'(1);
        end
    end

    assign o_sat_cnt = r_sat_cnt;
`else
    logic w_unused_clr;
    assign w_unused_clr = i_clr_cnt;
    assign o_sat_cnt    = '0;
`endif
endmodule

// File: tb/tb_requant_sat_pipe.sv
// Self-checking bench for requant_sat_pipe: vector table, backpressure, reset flush, counter corners.
module tb_requant_sat_pipe;
    import requant_pkg::*;

`ifdef REQUANT_SAT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct packed {
        logic signed [3:0][31:0] psum;
        logic signed [3:0][31:0] bias;
        logic signed [3:0][31:0] exp;
        logic [4:0]              shift;
        logic                    relu;
        logic [3:0]              flag;
    } vec_t;

    typedef struct packed {
        logic [NUM_CH*O_SUM_BW-1:0] psum;
        logic [NUM_CH-1:0]          flag;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              clr_cnt;
    logic [CNT_BW-1:0] sat_cnt;

    requant_sat_pipe_if bus ();

    requant_sat_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .io_bus    (bus),
        .i_clr_cnt (clr_cnt),
        .o_sat_cnt (sat_cnt)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_out  = 0;
    exp_t        sb[$];
    logic [31:0] exp_cnt = '0;
    vec_t        vecs[12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic vec_t mk(input int p0, p1, p2, p3, input int b0, b1, b2, b3,
                                input int sh, input bit rl,
                                input int e0, e1, e2, e3, input bit [3:0] f);
        vec_t v;
        v.psum[0] = p0; v.psum[1] = p1; v.psum[2] = p2; v.psum[3] = p3;
        v.bias[0] = b0; v.bias[1] = b1; v.bias[2] = b2; v.bias[3] = b3;
        v.exp[0]  = e0; v.exp[1]  = e1; v.exp[2]  = e2; v.exp[3]  = e3;
        v.shift   = 5'(sh);
        v.relu    = rl;
        v.flag    = f;
        return v;
    endfunction

    // Reference arithmetic in 64-bit integers, filling exp/flag of a vector.
    function automatic vec_t ref_fill(input vec_t v);
        longint sum, r;
        int     s;
        for (int c = 0; c < 4; c++) begin
            sum = longint'($signed(v.psum[c])) + longint'($signed(v.bias[c]));
            s   = (int'(v.shift) > 22) ? 22 : int'(v.shift);
            r   = sum;
            if (s > 0) r = (sum + (longint'(1) <<< (s - 1))) >>> s;
            if (v.relu && r < 0) r = 0;
            v.flag[c] = 1'b0;
            if (r > 32767) begin
                r = 32767; v.flag[c] = 1'b1;
            end else if (r < -32768) begin
                r = -32768; v.flag[c] = 1'b1;
            end
            v.exp[c] = int'(r);
        end
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        for (int c = 0; c < 4; c++) begin
            v.psum[c] = int'($urandom_range(0, 2097151)) - 1048576;
            v.bias[c] = int'($urandom_range(0, 65535)) - 32768;
        end
        v.shift = 5'($urandom_range(0, 8));
        v.relu  = 1'($urandom_range(0, 1));
        v.exp   = '0;
        v.flag  = '0;
        return ref_fill(v);
    endfunction

    task automatic send(input vec_t v);
        exp_t e;
        int   waited;
        for (int c = 0; c < NUM_CH; c++) begin
            bus.i_psum[c*I_SUM_BW +: I_SUM_BW] = v.psum[c][I_SUM_BW-1:0];
            bus.i_bias[c*BIAS_BW +: BIAS_BW]   = v.bias[c][BIAS_BW-1:0];
            e.psum[c*O_SUM_BW +: O_SUM_BW]     = v.exp[c][O_SUM_BW-1:0];
        end
        e.flag        = v.flag;
        bus.i_shift   = v.shift;
        bus.i_relu_en = v.relu;
        bus.i_valid   = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!bus.o_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("send_ready", 64'(bus.o_ready), 64'd1);
        if (bus.o_ready) sb.push_back(e);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on output handshakes, checks stall behaviour and the counter.
    initial begin
        exp_t        e;
        logic        prev_stall = 1'b0;
        logic [63:0] prev_psum  = '0;
        logic [3:0]  prev_flag  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_cnt    = '0;
                prev_stall = 1'b0;
            end else begin
                chk("sat_cnt", 64'(sat_cnt), 64'(exp_cnt));
                if (prev_stall) begin
                    chk("stall_valid", 64'(bus.o_valid), 64'd1);
                    chk("stall_psum", 64'(bus.o_psum), prev_psum);
                    chk("stall_flag", 64'(bus.o_sat_flag), 64'(prev_flag));
                end
                if (!bus.o_valid) chk("ready_idle", 64'(bus.o_ready), 64'd1);
                else if (!bus.i_ready) chk("ready_stall", 64'(bus.o_ready), 64'd0);
                prev_stall = bus.o_valid && !bus.i_ready;
                prev_psum  = 64'(bus.o_psum);
                prev_flag  = bus.o_sat_flag;
                if (bus.o_valid && bus.i_ready) begin
                    n_out++;
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", 64'(bus.o_psum), 64'd0);
                        n_fail++;
                        $display("FAIL unexpected_beat: output with empty scoreboard");
                    end else begin
                        e = sb.pop_front();
                        chk("out_psum", 64'(bus.o_psum), 64'(e.psum));
                        chk("out_flag", 64'(bus.o_sat_flag), 64'(e.flag));
                        if (CNT_ON) begin
                            if (clr_cnt) exp_cnt = '0;
                            else if ((|e.flag) && exp_cnt != '1) exp_cnt = exp_cnt + 32'd1;
                        end
                    end
                end else if (clr_cnt) begin
                    exp_cnt = '0;
                end
            end
        end
    end

    initial begin
        int out_before;
        vecs[0]  = mk(40000, 0, 0, 0,  0, 0, 0, 0,  0, 0,  32767, 0, 0, 0, 4'b0001);
        vecs[1]  = mk(-40000, 0, 0, 0,  0, 0, 0, 0,  0, 0,  -32768, 0, 0, 0, 4'b0001);
        vecs[2]  = mk(100, 102, -6, 0,  -3, 0, 0, 0,  2, 0,  24, 26, -1, 0, 4'b0000);
        vecs[3]  = mk(-500, 0, 0, 0,  0, 0, 0, 0,  0, 1,  0, 0, 0, 0, 4'b0000);
        vecs[4]  = mk(-500, 0, 0, 0,  0, 0, 0, 0,  0, 0,  -500, 0, 0, 0, 4'b0000);
        vecs[5]  = mk(32767, -32768, 32768, -32769,  0, 0, 0, 0,  0, 0,
                      32767, -32768, 32767, -32768, 4'b1100);
        vecs[6]  = mk(40000, -40000, -1, 1,  0, 0, 0, 0,  0, 1,  32767, 0, 0, 1, 4'b0001);
        vecs[7]  = mk(-3, -1, 3, 1,  0, 0, 0, 0,  1, 0,  -1, 0, 2, 1, 4'b0000);
        vecs[8]  = mk(1048575, -1048576, -1048576, 1048575,  32767, -32768, 0, 0,  21, 0,
                      1, -1, 0, 0, 4'b0000);
        vecs[9]  = mk(1048575, -1048576, 1000, -1000,  32767, -32768, 0, 0,  31, 0,
                      0, 0, 0, 0, 4'b0000);
        vecs[10] = mk(32000, -32000, 0, 0,  1000, -1000, 32767, -32768,  0, 0,
                      32767, -32768, 32767, -32768, 4'b0011);
        vecs[11] = mk(1048575, -1048576, 24, -24,  32767, -32768, 0, 0,  4, 0,
                      32767, -32768, 2, -1, 4'b0011);

        reset = 1'b1; clr_cnt = 1'b0;
        bus.i_valid = 1'b0; bus.i_ready = 1'b1; bus.i_psum = '0; bus.i_bias = '0;
        bus.i_shift = '0; bus.i_relu_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_o_psum", 64'(bus.o_psum), 64'd0);
        chk("rst_o_flag", 64'(bus.o_sat_flag), 64'd0);
        chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 12; i++) send(vecs[i]);
        drain();
        chk("cnt_after_table", 64'(sat_cnt), CNT_ON ? 64'd6 : 64'd0);

        // Six back-to-back beats with the sink stalled for cycles 2..7.
        fork
            begin
                for (int i = 0; i < 6; i++) send(rnd_vec());
            end
            begin
                @(posedge clk); #1;
                bus.i_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1;
                bus.i_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight: both must vanish.
        send(vecs[0]);
        send(vecs[1]);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        chk("flush_o_valid", 64'(bus.o_valid), 64'd0);
        chk("flush_sat_cnt", 64'(sat_cnt), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        out_before = n_out;
        repeat (8) @(posedge clk);
        #1;
        chk("flush_no_ghost", 64'(n_out - out_before), 64'd0);

        // Counter clear coincident with a clipping output handshake; also checks latency.
        send(vecs[0]);
        drain();
        chk("cnt_pre_clr", 64'(sat_cnt), CNT_ON ? 64'd1 : 64'd0);
        send(vecs[1]);
        @(negedge clk);
        chk("lat_cycle1", 64'(bus.o_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_cycle2", 64'(bus.o_valid), 64'd0);
        @(posedge clk); #1;
        clr_cnt = 1'b1;
        @(negedge clk);
        chk("lat_cycle3", 64'(bus.o_valid), 64'd1);
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        drain();
        chk("cnt_clr_wins", 64'(sat_cnt), 64'd0);

`ifdef REQUANT_SAT_CNT_EN
        force dut.r_sat_cnt = 32'hFFFF_FFFE;
        exp_cnt = 32'hFFFF_FFFE;
        @(posedge clk); #1;
        release dut.r_sat_cnt;
        send(vecs[0]);
        send(vecs[10]);
        send(vecs[1]);
        drain();
        chk("cnt_saturate", 64'(sat_cnt), 64'hFFFF_FFFF);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
